player_action_input: RTL and testbench

Keyboard-driven action decoder for the human player's turn; the input-side counterpart of the on-screen action button labels. It converts USB HID keycodes ([F], [C], [B], [R], digits, Enter, Backspace, Esc) into one validated player action with an 11-bit amount. It hands that action to the game FSM over a valid/ready handshake. While an amount is being typed, it exposes the entry value for the text overlay.

---
 rtl/player_action_input.sv | 122 ++++++++++++
 tb/tb_player_action_input.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/player_action_input.sv
// player_action_input: decodes HID keystrokes into one validated poker action with an amount,
// handed to the game FSM over valid/ready.
module player_action_input #(
    parameter logic [7:0] KEY_F = 8'h09,
    parameter logic [7:0] KEY_C = 8'h06,
    parameter logic [7:0] KEY_B = 8'h05,
    parameter logic [7:0] KEY_R = 8'h15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  keycode,
    input  logic        enable,
    input  logic        if_BetCheck,
    input  logic [10:0] min_bet_or_raise,
    input  logic [10:0] call_size,
    input  logic [10:0] stack,
    input  logic        action_ready,
    output logic        action_valid,
    output logic [2:0]  action,
    output logic [10:0] action_amount,
    output logic        entry_active,
    output logic [10:0] entry_value,
    output logic        entry_error
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENTRY = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;
    logic [1:0]  state_q, state_d;
    logic [7:0]  key_prev_q;
    logic [2:0]  action_q, action_d;
    logic [10:0] amount_q, amount_d;
    logic [10:0] entry_q, entry_d;
    logic        err_q, err_d;
    logic        ev, is_digit, enter_ok;
    logic [3:0]  digit;
    logic [14:0] cand;
    logic [10:0] call_amt;
    assign ev       = (keycode != 8'h00) && (keycode != key_prev_q);
    assign is_digit = (keycode >= 8'h1E) && (keycode <= 8'h27);
    assign digit    = (keycode == 8'h27) ? 4'd0 : 4'(keycode - 8'h1D);
    // 15 bits holds 2047*10+9 without wrap, so the stack comparison is exact
    assign cand     = 15'(entry_q) * 15'd10 + 15'(digit);
    assign call_amt = (call_size < stack) ? call_size : stack;
    assign enter_ok = (entry_q != 11'd0) && ((entry_q >= min_bet_or_raise) || (entry_q == stack));
    always_comb begin
        state_d  = state_q;
        action_d = action_q;
        amount_d = amount_q;
        entry_d  = entry_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: if (enable && ev) begin
                if (keycode == KEY_F) begin
                    state_d  = ISSUE;
                    action_d = 3'd0;
                    amount_d = 11'd0;
                end else if (keycode == KEY_C) begin
                    state_d  = ISSUE;
                    action_d = if_BetCheck ? 3'd1 : 3'd2;
                    amount_d = if_BetCheck ? 11'd0 : call_amt;
                end else if (keycode == KEY_B || keycode == KEY_R) begin
                    if (if_BetCheck == (keycode == KEY_B)) begin
                        state_d  = ENTRY;
                        action_d = if_BetCheck ? 3'd3 : 3'd4;
                        entry_d  = 11'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ENTRY: if (!enable) begin
                state_d = IDLE;
                entry_d = 11'd0;
            end else if (ev) begin
                if (is_digit) begin
                    entry_d = (cand <= 15'(stack)) ? cand[10:0] : entry_q;
                    err_d   = cand > 15'(stack);
                end else if (keycode == KEY_BKSP) begin
                    entry_d = entry_q / 11'd10;
                end else if (keycode == KEY_ESC) begin
                    state_d = IDLE;
                    entry_d = 11'd0;
                end else if (keycode == KEY_ENTER) begin
                    state_d  = enter_ok ? ISSUE : ENTRY;
                    amount_d = enter_ok ? entry_q : amount_q;
                    err_d    = !enter_ok;
                end
            end
            ISSUE: if (action_ready) begin
                state_d = IDLE;
                entry_d = 11'd0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            key_prev_q <= 8'h00;
            action_q   <= 3'd0;
            amount_q   <= 11'd0;
            entry_q    <= 11'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= keycode;
            action_q   <= action_d;
            amount_q   <= amount_d;
            entry_q    <= entry_d;
            err_q      <= err_d;
        end
    end
    assign action_valid  = state_q == ISSUE;
    assign entry_active  = state_q == ENTRY;
    assign action        = action_q;
    assign action_amount = amount_q;
    assign entry_value   = entry_q;
    assign entry_error   = err_q;
endmodule

// File: tb/tb_player_action_input.sv
// tb_player_action_input: directed test-plan scenarios plus randomized keystrokes checked
// against a behavioural model of the action decoder.
module tb_player_action_input;
    localparam logic [7:0] KF = 8'h09, KC = 8'h06, KB = 8'h05, KR = 8'h15;
    localparam logic [7:0] ENT = 8'h28, ESC = 8'h29, BSP = 8'h2A;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic        enable = 1'b0;
    logic        if_BetCheck = 1'b0;
    logic [10:0] min_bet_or_raise = 11'd0;
    logic [10:0] call_size = 11'd0;
    logic [10:0] stack = 11'd0;
    logic        action_ready = 1'b0;
    logic        action_valid;
    logic [2:0]  action;
    logic [10:0] action_amount;
    logic        entry_active;
    logic [10:0] entry_value;
    logic        entry_error;
    int n_checks = 0;
    int n_errors = 0;
    // reference model: mode 0 waiting, 1 typing an amount, 2 offering an action
    int m_mode, m_prev, m_act, m_amt, m_entry, m_pend;
    bit m_err;
    player_action_input dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .enable(enable),
        .if_BetCheck(if_BetCheck), .min_bet_or_raise(min_bet_or_raise),
        .call_size(call_size), .stack(stack), .action_ready(action_ready),
        .action_valid(action_valid), .action(action), .action_amount(action_amount),
        .entry_active(entry_active), .entry_value(entry_value), .entry_error(entry_error)
    );
    always #5 Clk = ~Clk;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_act = 0; m_amt = 0; m_entry = 0; m_pend = 0; m_err = 0;
    endtask
    task automatic model_edge();
        int k, cand, st;
        bit ev;
        k  = int'(keycode);
        st = int'(stack);
        ev = (k != 0) && (k != m_prev);
        m_prev = k;
        m_err = 0;
        if (m_mode == 0) begin
            if (enable && ev) begin
                if (k == KF) begin m_mode = 2; m_act = 0; m_amt = 0; end
                else if (k == KC && if_BetCheck) begin m_mode = 2; m_act = 1; m_amt = 0; end
                else if (k == KC) begin
                    m_mode = 2; m_act = 2;
                    m_amt = (int'(call_size) < st) ? int'(call_size) : st;
                end
                else if (k == KB && if_BetCheck) begin m_mode = 1; m_pend = 3; m_entry = 0; end
                else if (k == KR && !if_BetCheck) begin m_mode = 1; m_pend = 4; m_entry = 0; end
                else if (k == KB || k == KR) m_err = 1;
            end
        end else if (m_mode == 1) begin
            if (!enable) begin m_mode = 0; m_entry = 0; end
            else if (ev) begin
                if (k >= 8'h1E && k <= 8'h27) begin
                    cand = m_entry * 10 + ((k == 8'h27) ? 0 : k - 8'h1D);
                    if (cand <= st) m_entry = cand; else m_err = 1;
                end else if (k == BSP) m_entry = m_entry / 10;
                else if (k == ESC) begin m_mode = 0; m_entry = 0; end
                else if (k == ENT) begin
                    if (m_entry != 0 && (m_entry >= int'(min_bet_or_raise) || m_entry == st)) begin
                        m_mode = 2; m_act = m_pend; m_amt = m_entry;
                    end else m_err = 1;
                end
            end
        end else if (action_ready) begin
            m_mode = 0; m_entry = 0;
        end
    endtask
    task automatic step(input logic [7:0] k);
        keycode = k;
        @(posedge Clk);
        model_edge();
        #1;
        check("valid", int'(action_valid), int'(m_mode == 2));
        if (m_mode == 2) begin
            check("action", int'(action), m_act);
            check("amount", int'(action_amount), m_amt);
        end
        check("entry_active", int'(entry_active), int'(m_mode == 1));
        check("entry_value", int'(entry_value), m_entry);
        check("entry_error", int'(entry_error), int'(m_err));
    endtask
    task automatic press(input logic [7:0] k);
        step(k);
        step(8'h00);
    endtask
    initial begin
        int cnt;
        int r;
        logic [7:0] k;
        logic [7:0] cmds [7];
        cmds = '{KF, KC, KB, KR, ENT, ESC, BSP};
        model_reset();
        #1;
        check("rst_valid", int'(action_valid), 0);
        check("rst_entry", int'(entry_value), 0);
        check("rst_err", int'(entry_error), 0);
        #20 Reset_n = 1'b1;
        // call capped at the stack
        enable = 1; if_BetCheck = 0; call_size = 40; stack = 25;
        step(KC);
        check("call_valid", int'(action_valid), 1);
        check("call_act", int'(action), 2);
        check("call_amt", int'(action_amount), 25);
        call_size = 100; stack = 300;
        step(8'h00);
        step(8'h00);
        check("call_hold", int'(action_amount), 25);
        action_ready = 1;
        step(8'h00);
        check("call_done", int'(action_valid), 0);
        action_ready = 0;
        // bet entry with a rejected enter
        if_BetCheck = 1; min_bet_or_raise = 20; stack = 500;
        press(KB);
        check("bet_active", int'(entry_active), 1);
        press(8'h1E); check("bet_e1", int'(entry_value), 1);
        press(8'h22); check("bet_e15", int'(entry_value), 15);
        step(ENT); check("bet_enter_err", int'(entry_error), 1);
        step(8'h00); check("bet_err_pulse", int'(entry_error), 0);
        press(BSP); check("bet_bs", int'(entry_value), 1);
        press(BSP); check("bet_bs0", int'(entry_value), 0);
        press(8'h22); press(8'h27); check("bet_e50", int'(entry_value), 50);
        step(ENT);
        check("bet_act", int'(action), 3);
        check("bet_amt", int'(action_amount), 50);
        action_ready = 1; step(8'h00); action_ready = 0;
        // raise entry bounded by the stack
        if_BetCheck = 0; stack = 120; min_bet_or_raise = 40;
        press(KR); press(8'h1E); press(8'h1F);
        step(8'h26);
        check("raise_over", int'(entry_error), 1);
        check("raise_keep", int'(entry_value), 12);
        step(8'h00);
        step(ENT); check("raise_min_err", int'(entry_error), 1);
        step(8'h00);
        press(8'h27); step(ENT);
        check("raise_act", int'(action), 4);
        check("raise_amt", int'(action_amount), 120);
        action_ready = 1; step(8'h00);
        // held key issues one fold
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(KF);
            if (action_valid) cnt++;
        end
        check("fold_once", cnt, 1);
        step(8'h00);
        step(KF);
        check("fold_again", int'(action_valid), 1);
        step(8'h00);
        action_ready = 0;
        // leaving entry by enable drop and by Esc
        if_BetCheck = 1; stack = 500;
        press(KB); press(8'h24);
        check("e7", int'(entry_value), 7);
        enable = 0; step(8'h00);
        check("drop_active", int'(entry_active), 0);
        check("drop_value", int'(entry_value), 0);
        enable = 1;
        press(KB); press(8'h24); step(ESC);
        check("esc_active", int'(entry_active), 0);
        check("esc_value", int'(entry_value), 0);
        step(8'h00);
        // asynchronous reset while offering an action
        step(KF);
        check("pre_rst_valid", int'(action_valid), 1);
        #3 Reset_n = 1'b0;
        #1;
        check("async_valid", int'(action_valid), 0);
        check("async_action", int'(action), 0);
        model_reset();
        keycode = 8'h00;
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(8'h00);
        check("post_rst_idle", int'(action_valid), 0);
        // randomized traffic
        k = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 9);
            if (r >= 3 && r <= 4) k = 8'h00;
            else if (r >= 5 && r <= 7) k = 8'(8'h1E + $urandom_range(0, 9));
            else if (r == 8) k = cmds[$urandom_range(0, 6)];
            else if (r == 9) k = 8'($urandom_range(0, 255));
            enable = $urandom_range(0, 15) != 0;
            action_ready = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 7) == 0) if_BetCheck = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) stack = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 7) == 0) min_bet_or_raise = 11'($urandom_range(0, 400));
            if ($urandom_range(0, 7) == 0) call_size = 11'($urandom_range(0, 2047));
            step(k);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
